// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Purpose:
//   Holds the fetch program counter and chooses its next value every cycle.
//   The next value is either the sequential address (pc+4) or a redirect
//   raised by the decode stage:
//     - a taken conditional branch (id_pc + 4 + offset*4)
//     - an absolute jump           ({id_pc[top:28], j_index, 2'b00})
//     - a register jump            (jr_target as given)
//     - an exception return        (epc)             [optional feature]
//     - an exception entry         (EXC_PC)          [optional feature]
//   While fetch is stalled the PC holds.  A redirect that arrives during a
//   stall is remembered, together with its priority, so that it can be
//   applied on the first unstalled edge.  Exception entry is never deferred.
//
// Configuration:
//   PC_SEQUENCER_EXC_EN  defined   : exc_valid / eret_valid / epc are honoured
//                                    with priority exc > eret > jr > j > br.
//   PC_SEQUENCER_EXC_EN  undefined : those inputs and EXC_PC are ignored and
//                                    the priority is jr > j > br.
//
// Parameters:
//   WIDTH     PC / address width in bits (32 or more)
//   RESET_PC  value forced into pc by reset
//   EXC_PC    exception entry vector
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous reset, active low
//   stall             1 = hold the PC this cycle
//   id_pc             PC of the instruction in decode (branch/jump base)
//   br_valid/br_taken conditional branch present / compare result
//   br_offset         sign-extended word offset of the branch
//   j_valid/j_index   absolute jump present / 26-bit index field
//   jr_valid/jr_target register jump present / register value
//   exc_valid         exception request
//   eret_valid/epc    exception return request / return address
//   pc                registered fetch PC
//   npc               value pc will take at the next rising edge
//   redirect_pending  a stalled redirect is waiting for the stall to clear
//   pc_misalign       pc is not word aligned
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_PC   = WIDTH'(32'h0000_4180)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [WIDTH-1:0] id_pc,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_offset,
  input  logic             j_valid,
  input  logic [25:0]      j_index,
  input  logic             jr_valid,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             exc_valid,
  input  logic             eret_valid,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] npc,
  output logic             redirect_pending,
  output logic             pc_misalign
);

  // Controller states: RUN fetches normally, PEND holds a deferred redirect.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  // Redirect priority levels, ordered so that a larger value wins.
  // Exception entry is not listed: it bypasses the pending mechanism.
  typedef enum logic [2:0] {
    PRIO_NONE = 3'd0,
    PRIO_BR   = 3'd1,
    PRIO_J    = 3'd2,
    PRIO_JR   = 3'd3,
    PRIO_ERET = 3'd4
  } prio_e;

  // Registered state
  state_e           state_q,       state_d;
  logic [WIDTH-1:0] pc_q,          pc_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  prio_e            pend_prio_q,   pend_prio_d;

  // Candidate targets and the winning non-exception redirect this cycle
  logic [WIDTH-1:0] seq_target;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] j_target;
  logic [WIDTH-1:0] redir_target;
  prio_e            redir_prio;
  logic             redir_valid;
  logic             exc_req;

  // Target arithmetic wraps modulo 2^WIDTH; the shifted-out offset bits are
  // irrelevant because the offset is already sign extended to WIDTH.
  assign seq_target = pc_q + WIDTH'(4);
  assign br_target  = id_pc + WIDTH'(4) + (br_offset << 2);
  assign j_target   = {id_pc[WIDTH-1:28], j_index, 2'b00};

`ifdef PC_SEQUENCER_EXC_EN
  assign exc_req = exc_valid;
`else
  // Exception support compiled out: the exception inputs and the entry
  // vector are deliberately left without effect.
  logic unused_exc;
  assign unused_exc = ^{exc_valid, eret_valid, epc, EXC_PC};
  assign exc_req    = 1'b0;
`endif

  // Pick the highest-priority non-exception redirect.  Later assignments
  // override earlier ones, so the list runs from lowest to highest priority.
  // A branch that is not taken is not a redirect at all.
  always_comb begin
    redir_prio   = PRIO_NONE;
    redir_target = '0;
    if (br_valid && br_taken) begin
      redir_prio   = PRIO_BR;
      redir_target = br_target;
    end
    if (j_valid) begin
      redir_prio   = PRIO_J;
      redir_target = j_target;
    end
    if (jr_valid) begin
      redir_prio   = PRIO_JR;
      redir_target = jr_target;
    end
`ifdef PC_SEQUENCER_EXC_EN
    if (eret_valid) begin
      redir_prio   = PRIO_ERET;
      redir_target = epc;
    end
`endif
  end

  assign redir_valid = (redir_prio != PRIO_NONE);

  // Next-state logic.  Exception entry wins over everything, including a
  // stall and a pending redirect.  Otherwise RUN either advances or defers
  // a redirect into PEND, and PEND either upgrades the deferred redirect or
  // applies it once the stall lifts (ignoring whatever decode offers then).
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    pend_prio_d   = pend_prio_q;

    if (exc_req) begin
      state_d       = ST_RUN;
      pc_d          = EXC_PC;
      pend_target_d = '0;
      pend_prio_d   = PRIO_NONE;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!stall) begin
            pc_d = redir_valid ? redir_target : seq_target;
          end else if (redir_valid) begin
            state_d       = ST_PEND;
            pend_target_d = redir_target;
            pend_prio_d   = redir_prio;
          end
        end
        ST_PEND: begin
          if (!stall) begin
            state_d       = ST_RUN;
            pc_d          = pend_target_q;
            pend_target_d = '0;
            pend_prio_d   = PRIO_NONE;
          end else if (redir_prio > pend_prio_q) begin
            pend_target_d = redir_target;
            pend_prio_d   = redir_prio;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State registers; reset throws away any deferred redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      pend_target_q <= '0;
      pend_prio_q   <= PRIO_NONE;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      pend_prio_q   <= pend_prio_d;
    end
  end

  assign pc               = pc_q;
  assign npc              = pc_d;
  assign redirect_pending = (state_q == ST_PEND);
  assign pc_misalign      = |pc_q[1:0];

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer.  A reference model of the fetch PC
// (current pc, whether a redirect is deferred, its rank and its target) is
// advanced on every rising edge from the documented redirect rules, and a
// compare process checks pc, npc, redirect_pending and pc_misalign against
// it on every falling edge.  Directed sequences with literal expectations
// pin down the model, then randomized stimulus exercises the rest.
// Follows PC_SEQUENCER_EXC_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int          WIDTH    = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] id_pc;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_offset;
  logic        j_valid;
  logic [25:0] j_index;
  logic        jr_valid;
  logic [31:0] jr_target;
  logic        exc_valid;
  logic        eret_valid;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        redirect_pending;
  logic        pc_misalign;

  int nChecks = 0;
  int nFails  = 0;
  bit checkEn = 0;

  // Reference model state
  logic [31:0] mPc;
  bit          mPend;
  int          mRank;
  logic [31:0] mTgt;

  pc_sequencer #(
    .WIDTH   (WIDTH),
    .RESET_PC(RESET_PC),
    .EXC_PC  (EXC_PC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .id_pc           (id_pc),
    .br_valid        (br_valid),
    .br_taken        (br_taken),
    .br_offset       (br_offset),
    .j_valid         (j_valid),
    .j_index         (j_index),
    .jr_valid        (jr_valid),
    .jr_target       (jr_target),
    .exc_valid       (exc_valid),
    .eret_valid      (eret_valid),
    .epc             (epc),
    .pc              (pc),
    .npc             (npc),
    .redirect_pending(redirect_pending),
    .pc_misalign     (pc_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: actual %h, required %h", name, $time, act, exp);
    end
  endtask

  // Rank of the strongest non-exception request on the inputs right now
  // (0 = none) and the address it asks for; then what the model moves to.
  function automatic void modelNext(output logic [31:0] nPc, output bit nPend,
                                    output int nRank, output logic [31:0] nTgt);
    int          rank;
    logic [31:0] tgt;
    rank = 0;
    tgt  = 32'h0;
    if (br_valid && br_taken) begin
      rank = 1;
      tgt  = id_pc + 32'd4 + br_offset * 32'd4;
    end
    if (j_valid) begin
      rank = 2;
      tgt  = (id_pc & 32'hF000_0000) | ({6'b0, j_index} * 32'd4);
    end
    if (jr_valid) begin
      rank = 3;
      tgt  = jr_target;
    end
`ifdef PC_SEQUENCER_EXC_EN
    if (eret_valid) begin
      rank = 4;
      tgt  = epc;
    end
`endif
    nPc   = mPc;
    nPend = mPend;
    nRank = mRank;
    nTgt  = mTgt;
`ifdef PC_SEQUENCER_EXC_EN
    if (exc_valid) begin
      nPc   = EXC_PC;
      nPend = 0;
      nRank = 0;
      nTgt  = 32'h0;
      return;
    end
`endif
    if (!mPend) begin
      if (!stall) begin
        nPc = (rank > 0) ? tgt : mPc + 32'd4;
      end else if (rank > 0) begin
        nPend = 1;
        nRank = rank;
        nTgt  = tgt;
      end
    end else begin
      if (!stall) begin
        nPc   = mTgt;
        nPend = 0;
        nRank = 0;
        nTgt  = 32'h0;
      end else if (rank > mRank) begin
        nRank = rank;
        nTgt  = tgt;
      end
    end
  endfunction

  // Model advances on the same edges and resets as the design.
  always @(posedge clk or negedge reset) begin : modelUpdate
    logic [31:0] aPc;
    bit          aPend;
    int          aRank;
    logic [31:0] aTgt;
    if (!reset) begin
      mPc   <= RESET_PC;
      mPend <= 0;
      mRank <= 0;
      mTgt  <= 32'h0;
    end else begin
      modelNext(aPc, aPend, aRank, aTgt);
      mPc   <= aPc;
      mPend <= aPend;
      mRank <= aRank;
      mTgt  <= aTgt;
    end
  end

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clk) begin : compare
    logic [31:0] ePc;
    bit          ePend;
    int          eRank;
    logic [31:0] eTgt;
    if (checkEn && reset) begin
      modelNext(ePc, ePend, eRank, eTgt);
      checkOutput("pc", pc, mPc);
      checkOutput("npc", npc, ePc);
      checkOutput("redirect_pending", {31'b0, redirect_pending}, {31'b0, mPend});
      checkOutput("pc_misalign", {31'b0, pc_misalign}, {31'b0, (mPc[1:0] != 2'b00)});
    end
  end

  task automatic clearInputs();
    stall      = 0;
    id_pc      = 32'h0;
    br_valid   = 0;
    br_taken   = 0;
    br_offset  = 32'h0;
    j_valid    = 0;
    j_index    = 26'h0;
    jr_valid   = 0;
    jr_target  = 32'h0;
    exc_valid  = 0;
    eret_valid = 0;
    epc        = 32'h0;
  endtask

  // Moves to just after the next rising edge, where inputs are changed.
  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  // Moves to just after the next falling edge, where literals are checked.
  task automatic atSample();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    stall      = ($urandom_range(0, 9) < 3);
    id_pc      = $urandom;
    br_valid   = ($urandom_range(0, 9) < 3);
    br_taken   = $urandom_range(0, 1);
    br_offset  = $urandom;
    j_valid    = ($urandom_range(0, 9) < 2);
    j_index    = 26'($urandom);
    jr_valid   = ($urandom_range(0, 9) < 2);
    jr_target  = $urandom;
    exc_valid  = ($urandom_range(0, 19) == 0);
    eret_valid = ($urandom_range(0, 9) < 2);
    epc        = $urandom;
  endtask

  initial begin
    clearInputs();
    reset = 1;
    #1 reset = 0;
    #1;
    checkOutput("reset_pc", pc, RESET_PC);
    checkOutput("reset_pending", {31'b0, redirect_pending}, 32'h0);

    // Release reset away from any edge; idle fetch walks by four.
    @(posedge clk);
    @(posedge clk);
    #2;
    reset   = 1;
    checkEn = 1;
    atSample();
    checkOutput("idle_pc0", pc, 32'h0000_3000);
    atSample();
    checkOutput("idle_pc1", pc, 32'h0000_3004);
    atSample();
    checkOutput("idle_pc2", pc, 32'h0000_3008);
    atSample();
    checkOutput("idle_pc3", pc, 32'h0000_300C);

    // Backward taken branch, then the same branch not taken.
    nextCycle();
    id_pc     = 32'h0000_3010;
    br_valid  = 1;
    br_taken  = 1;
    br_offset = 32'hFFFF_FFFE;
    atSample();
    checkOutput("br_taken_npc", npc, 32'h0000_300C);
    nextCycle();
    checkOutput("br_taken_pc", pc, 32'h0000_300C);
    br_taken = 0;
    atSample();
    checkOutput("br_not_taken_npc", npc, 32'h0000_3010);
    nextCycle();
    checkOutput("br_not_taken_pc", pc, 32'h0000_3010);
    clearInputs();

    // Jump under stall is deferred, then applied on release.
    id_pc   = 32'h0000_3010;
    stall   = 1;
    j_valid = 1;
    j_index = 26'h0000C40;
    nextCycle();
    j_valid = 0;
    checkOutput("stall_j_hold0", pc, 32'h0000_3010);
    checkOutput("stall_j_pend0", {31'b0, redirect_pending}, 32'h1);
    nextCycle();
    checkOutput("stall_j_hold1", pc, 32'h0000_3010);
    nextCycle();
    checkOutput("stall_j_hold2", pc, 32'h0000_3010);
    checkOutput("stall_j_pend2", {31'b0, redirect_pending}, 32'h1);
    stall = 0;
    nextCycle();
    checkOutput("stall_j_release", pc, 32'h0000_3100);
    checkOutput("stall_j_cleared", {31'b0, redirect_pending}, 32'h0);

    // Deferred jump upgraded by a register jump to a misaligned address.
    stall   = 1;
    j_valid = 1;
    nextCycle();
    j_valid   = 0;
    jr_valid  = 1;
    jr_target = 32'h0000_3402;
    nextCycle();
    jr_valid = 0;
    stall    = 0;
    nextCycle();
    checkOutput("jr_upgrade_pc", pc, 32'h0000_3402);
    checkOutput("jr_upgrade_misalign", {31'b0, pc_misalign}, 32'h1);
    clearInputs();

    // Reset between edges while a redirect is deferred.
    stall   = 1;
    j_valid = 1;
    j_index = 26'h0000C40;
    nextCycle();
    checkOutput("pend_before_reset", {31'b0, redirect_pending}, 32'h1);
    #1 reset = 0;
    #1;
    checkOutput("async_reset_pc", pc, 32'h0000_3000);
    checkOutput("async_reset_pending", {31'b0, redirect_pending}, 32'h0);
    clearInputs();
    #1 reset = 1;
    nextCycle();
    checkOutput("first_after_reset", pc, 32'h0000_3004);

`ifdef PC_SEQUENCER_EXC_EN
    // Exception overrides a stall and a pending redirect; eret returns.
    stall   = 1;
    j_valid = 1;
    nextCycle();
    j_valid   = 0;
    exc_valid = 1;
    nextCycle();
    checkOutput("exc_pc", pc, 32'h0000_4180);
    checkOutput("exc_pending", {31'b0, redirect_pending}, 32'h0);
    clearInputs();
    eret_valid = 1;
    epc        = 32'h0000_3020;
    nextCycle();
    checkOutput("eret_pc", pc, 32'h0000_3020);
    clearInputs();
`endif

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 3000; i++) begin
      nextCycle();
      applyStimulus();
      if ($urandom_range(0, 199) == 0) begin
        #1 reset = 0;
        #1 reset = 1;
      end
    end

    nextCycle();
    checkEn = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
